// File: rtl/swo_uart_rx_pkg.sv
// SWO UART receiver shared trace constants.
// FSM encoding and clamp helpers for the trace register settings.
package swo_uart_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } swo_state_e;

  localparam logic [7:0] SWO_DIV_MIN  = 8'd3;
  localparam logic [3:0] SWO_DATA_MAX = 4'd8;

  function automatic logic [7:0] swo_clamp_div(
    input logic [7:0] div
  );
    return (div < SWO_DIV_MIN) ? SWO_DIV_MIN : div;
  endfunction

  function automatic logic [3:0] swo_clamp_bits(
    input logic [3:0] n
  );
    return (n == 4'd0 || n > SWO_DATA_MAX) ? SWO_DATA_MAX : n;
  endfunction

endpackage

// File: rtl/swo_uart_rx_sync.sv
// Reset-to-1 synchronizer for the SWO line.
// Emits the synchronized level and a registered falling-edge flag.
module swo_sync #(
  parameter int pSTAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic fall_o
);

  logic [pSTAGES-1:0] sync_q;
  logic               prev_q;
  logic               fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '1;
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[pSTAGES-2:0], d_i};
      prev_q <= sync_q[pSTAGES-1];
      fall_q <= prev_q & ~sync_q[pSTAGES-1];
    end
  end

  assign q_o    = prev_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/swo_uart_rx.sv
// SWO asynchronous trace receiver: oversampled UART framing,
// one-cycle byte/error pulses and a saturating error count.
module swo_uart_rx
  import swo_uart_rx_pkg::*;
#(
  parameter int pSYNC_STAGES = 2
) (
  input  logic       uart_clk,
  input  logic       reset_i,
  input  logic       I_swo,
  input  logic       I_swo_enable,
  input  logic [7:0] I_bitrate_div,
  input  logic [1:0] I_stop_bits,
  input  logic [3:0] I_data_bits,
  input  logic       I_clear_errors,
  output logic [7:0] O_data,
  output logic       O_data_valid,
  output logic       O_framing_error,
  output logic [7:0] O_frame_errors,
  output logic       O_busy
);

  logic       line;
  logic       fall;
  logic       sample;
  logic       err_d;
  logic [7:0] div_c;

  swo_state_e state_q;
  logic [7:0] cnt_q;
  logic [7:0] div_q;
  logic [3:0] nbits_q;
  logic       two_stop_q;
  logic [3:0] idx_q;
  logic [7:0] shift_q;
  logic       err_q;
  logic [7:0] data_q;
  logic       valid_q;
  logic       fe_q;
  logic [7:0] errs_q;

  swo_sync #(
    .pSTAGES(pSYNC_STAGES)
  ) u_sync (
    .clk_i (uart_clk),
    .rst_i (reset_i),
    .d_i   (I_swo),
    .q_o   (line),
    .fall_o(fall)
  );

  assign div_c  = swo_clamp_div(I_bitrate_div);
  assign sample = (cnt_q == 8'd0);
  assign err_d  = err_q | ~line;

  always_ff @(posedge uart_clk) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= SWO_DIV_MIN;
      nbits_q    <= SWO_DATA_MAX;
      two_stop_q <= 1'b0;
      idx_q      <= '0;
      shift_q    <= '0;
      err_q      <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      fe_q       <= 1'b0;
      errs_q     <= '0;
    end else begin
      valid_q <= 1'b0;
      fe_q    <= 1'b0;
      // count follows the error pulse, so a clear in that cycle keeps it
      if (I_clear_errors)
        errs_q <= {7'd0, fe_q};
      else if (fe_q && errs_q != 8'hFF)
        errs_q <= errs_q + 8'd1;
      if (!I_swo_enable) begin
        state_q <= ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (fall) begin
              div_q      <= div_c;
              nbits_q    <= swo_clamp_bits(I_data_bits);
              two_stop_q <= I_stop_bits[1];
              cnt_q      <= div_c >> 1;
              state_q    <= ST_START;
            end
          end
          ST_START: begin
            if (!sample) begin
              cnt_q <= cnt_q - 8'd1;
            end else begin
              cnt_q <= div_q;
              if (line) begin
                state_q <= ST_IDLE;
              end else begin
                shift_q <= '0;
                idx_q   <= '0;
                err_q   <= 1'b0;
                state_q <= ST_DATA;
              end
            end
          end
          ST_DATA: begin
            if (!sample) begin
              cnt_q <= cnt_q - 8'd1;
            end else begin
              cnt_q                <= div_q;
              shift_q[idx_q[2:0]]  <= line;
              if (idx_q == nbits_q - 4'd1) begin
                idx_q   <= '0;
                state_q <= ST_STOP;
              end else begin
                idx_q <= idx_q + 4'd1;
              end
            end
          end
          ST_STOP: begin
            if (!sample) begin
              cnt_q <= cnt_q - 8'd1;
            end else begin
              cnt_q <= div_q;
              if (two_stop_q && idx_q == 4'd0) begin
                err_q <= err_d;
                idx_q <= 4'd1;
              end else begin
                state_q <= ST_IDLE;
                if (err_d) begin
                  fe_q <= 1'b1;
                end else begin
                  valid_q <= 1'b1;
                  data_q  <= shift_q;
                end
              end
            end
          end
        endcase
      end
    end
  end

  assign O_data          = data_q;
  assign O_data_valid    = valid_q;
  assign O_framing_error = fe_q;
  assign O_frame_errors  = errs_q;
  assign O_busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_swo_uart_rx.sv
// Randomized frame-level bench for swo_uart_rx.
// Expected pulses are derived from the line timing rules.
`timescale 1ns/1ps
module tb_swo_uart_rx;

  logic       clk = 1'b0;
  logic       reset_i;
  logic       I_swo;
  logic       I_swo_enable;
  logic [7:0] I_bitrate_div;
  logic [1:0] I_stop_bits;
  logic [3:0] I_data_bits;
  logic       I_clear_errors;
  logic [7:0] O_data;
  logic       O_data_valid;
  logic       O_framing_error;
  logic [7:0] O_frame_errors;
  logic       O_busy;

  typedef struct {
    int         cyc;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       exp_q[$];
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  int         errs_m = 0;
  logic [7:0] last_data = 8'h00;
  int         busy_rise = -1;
  logic       busy_prev = 1'b0;

  swo_uart_rx #(
    .pSYNC_STAGES(2)
  ) dut (
    .uart_clk       (clk),
    .reset_i        (reset_i),
    .I_swo          (I_swo),
    .I_swo_enable   (I_swo_enable),
    .I_bitrate_div  (I_bitrate_div),
    .I_stop_bits    (I_stop_bits),
    .I_data_bits    (I_data_bits),
    .I_clear_errors (I_clear_errors),
    .O_data         (O_data),
    .O_data_valid   (O_data_valid),
    .O_framing_error(O_framing_error),
    .O_frame_errors (O_frame_errors),
    .O_busy         (O_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!reset_i) begin
      if (O_data_valid && O_framing_error)
        check("both pulses", 1, 0);
      if (O_data_valid || O_framing_error) begin
        if (exp_q.size() == 0) begin
          check("spurious pulse", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse cycle", cyc, e.cyc);
          check("pulse kind", O_framing_error, e.err);
          check("data", O_data, e.err ? last_data : e.data);
          check("busy at pulse", O_busy, 0);
          if (!e.err) last_data = e.data;
        end
      end
      if (O_busy && !busy_prev) busy_rise = cyc;
      busy_prev = O_busy;
    end
  end

  // Caller is at posedge+1; returns the expected pulse cycle.
  task automatic send_frame(input logic [7:0] data,
                            input logic [3:0] nb_raw,
                            input logic [1:0] sb_raw,
                            input logic [7:0] div_raw,
                            input int bad, input int gap,
                            output int pcyc);
    int d, nb, sb, t0;
    logic [8:0] mask;
    exp_t e;
    d  = (div_raw < 3) ? 3 : int'(div_raw);
    nb = (nb_raw == 0 || nb_raw > 8) ? 8 : int'(nb_raw);
    sb = (sb_raw >= 2) ? 2 : 1;
    mask = (9'd1 << nb) - 9'd1;
    t0 = cyc;
    I_bitrate_div = div_raw;
    I_data_bits   = nb_raw;
    I_stop_bits   = sb_raw;
    I_swo         = 1'b0;
    pcyc   = t0 + 5 + d / 2 + (nb + sb) * (d + 1);
    e.cyc  = pcyc;
    e.data = data & mask[7:0];
    e.err  = (bad >= 1 && bad <= sb);
    exp_q.push_back(e);
    if (e.err) errs_m = (errs_m >= 255) ? 255 : errs_m + 1;
    tick(d + 1);
    I_bitrate_div = 8'($urandom);
    I_data_bits   = 4'($urandom);
    I_stop_bits   = 2'($urandom);
    for (int i = 0; i < nb; i++) begin
      I_swo = data[i];
      tick(d + 1);
    end
    for (int s = 1; s <= sb; s++) begin
      I_swo = (bad == s) ? 1'b0 : 1'b1;
      tick(d + 1);
    end
    I_swo = 1'b1;
    check("busy rise", busy_rise, t0 + 4);
    tick(gap);
  endtask

  task automatic quiet_checks(input string tag);
    tick(150);
    check({tag, " pending"}, exp_q.size(), 0);
    check({tag, " busy"}, O_busy, 0);
    check({tag, " errs"}, O_frame_errors, errs_m);
  endtask

  initial begin
    int p, t0, bad, gap, sb;
    logic [7:0] b2b [4];
    b2b = '{8'h00, 8'hFF, 8'h55, 8'h80};
    reset_i = 1'b1;
    I_swo = 1'b1;
    I_swo_enable = 1'b1;
    I_bitrate_div = 8'd7;
    I_stop_bits = 2'd0;
    I_data_bits = 4'd8;
    I_clear_errors = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_i = 1'b0;
    check("rst data", O_data, 0);
    check("rst valid", O_data_valid, 0);
    check("rst ferr", O_framing_error, 0);
    check("rst errs", O_frame_errors, 0);
    check("rst busy", O_busy, 0);
    tick(5);

    send_frame(8'hA5, 4'd8, 2'd0, 8'd7, 0, 4, p);
    quiet_checks("nominal");

    send_frame(8'hF3, 4'd5, 2'd2, 8'd9, 0, 2, p);
    quiet_checks("5d2s");

    I_bitrate_div = 8'd15;
    t0 = cyc;
    I_swo = 1'b0;
    tick(2);
    I_swo = 1'b1;
    tick(40);
    check("glitch busy rise", busy_rise, t0 + 4);
    quiet_checks("glitch");

    send_frame(8'h3C, 4'd8, 2'd0, 8'd7, 1, 2, p);
    quiet_checks("ferr");
    send_frame(8'h66, 4'd8, 2'd3, 8'd6, 2, 2, p);
    quiet_checks("ferr stop2");

    for (int i = 0; i < 260; i++)
      send_frame(8'($urandom), 4'd1, 2'd0, 8'd0, 1, 2, p);
    quiet_checks("saturate");
    check("saturate 255", O_frame_errors, 255);

    I_clear_errors = 1'b1;
    tick(1);
    I_clear_errors = 1'b0;
    errs_m = 0;
    quiet_checks("clear");

    send_frame(8'h01, 4'd1, 2'd0, 8'd0, 1, 0, p);
    for (int k = 0; k < 100 && cyc < p; k++) tick(1);
    check("clear align", cyc, p);
    I_clear_errors = 1'b1;
    tick(1);
    I_clear_errors = 1'b0;
    errs_m = 1;
    quiet_checks("clear+err");

    I_bitrate_div = 8'd7;
    I_data_bits = 4'd8;
    I_swo = 1'b0;
    tick(8);
    I_swo = 1'b0;
    tick(8);
    I_swo = 1'b1;
    tick(8);
    I_swo_enable = 1'b0;
    tick(1);
    check("disable idle", O_busy, 0);
    tick(20);
    I_swo_enable = 1'b1;
    tick(5);
    quiet_checks("disable");
    send_frame(8'h96, 4'd8, 2'd0, 8'd7, 0, 3, p);
    quiet_checks("after disable");

    I_swo = 1'b0;
    tick(8);
    I_swo = 1'b1;
    tick(16);
    reset_i = 1'b1;
    tick(1);
    reset_i = 1'b0;
    errs_m = 0;
    last_data = 8'h00;
    check("reset idle", O_busy, 0);
    check("reset data", O_data, 0);
    check("reset errs", O_frame_errors, 0);
    tick(10);
    send_frame(8'hC3, 4'd8, 2'd0, 8'd7, 0, 3, p);
    quiet_checks("after reset");

    foreach (b2b[i])
      send_frame(b2b[i], 4'd8, 2'd1, 8'd7, 0, 0, p);
    quiet_checks("b2b");

    send_frame(8'h6B, 4'd8, 2'd0, 8'd0, 0, 3, p);
    send_frame(8'h6B, 4'd8, 2'd0, 8'd3, 0, 3, p);
    quiet_checks("div clamp");

    for (int i = 0; i < 40; i++) begin
      logic [1:0] sbr;
      sbr = 2'($urandom);
      sb  = (sbr >= 2) ? 2 : 1;
      bad = ($urandom_range(0, 3) == 0) ? $urandom_range(1, sb) : 0;
      gap = $urandom_range(0, 3) + ((bad != 0) ? 1 : 0);
      send_frame(8'($urandom), 4'($urandom), sbr,
                 8'($urandom_range(0, 12)), bad, gap, p);
    end
    quiet_checks("random");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
